// File: rtl/spectag_manager_pkg.sv
// Shared sizing, tag types and bit-vector helpers for the speculative-tag manager.
package spectag_manager_pkg;

  localparam int SPEC_STATES = 4;
  localparam int RENAME_RATE = 2;
  localparam int TAG_IDX_W   = $clog2(SPEC_STATES);
  localparam int CNT_W       = TAG_IDX_W + 1;

  typedef logic [SPEC_STATES-1:0] spectag_t;
  typedef logic [TAG_IDX_W-1:0]   tag_idx_t;
  typedef logic [CNT_W-1:0]       tag_cnt_t;

  function automatic tag_idx_t onehot_to_idx(input spectag_t oh);
    tag_idx_t idx;
    idx = '0;
    for (int t = 0; t < SPEC_STATES; t++) begin
      if (oh[t]) idx = idx | tag_idx_t'(t);
    end
    return idx;
  endfunction

  function automatic tag_cnt_t popcount(input spectag_t v);
    tag_cnt_t n;
    n = '0;
    for (int t = 0; t < SPEC_STATES; t++) begin
      n = n + tag_cnt_t'(v[t]);
    end
    return n;
  endfunction

endpackage

// File: rtl/spectag_alloc_pri.sv
// Lowest-index multi-grant picker: each requesting slot takes the lowest free tag
// not already taken by a lower slot.
module spectag_alloc_pri
  import spectag_manager_pkg::*;
(
  input  spectag_t                   free_vec,
  input  logic [RENAME_RATE-1:0]     req,
  output spectag_t [RENAME_RATE-1:0] grant,
  output tag_cnt_t                   grant_cnt
);

  spectag_t avail;
  spectag_t pick;

  always_comb begin
    avail     = free_vec;
    pick      = '0;
    grant     = '0;
    grant_cnt = '0;
    for (int i = 0; i < RENAME_RATE; i++) begin
      if (req[i]) begin
        pick     = avail & (~avail + spectag_t'(1));
        grant[i] = pick;
        avail    = avail & ~pick;
        if (|pick) grant_cnt = grant_cnt + tag_cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/spectag_manager.sv
// Allocates one-hot speculative tags at rename, tracks per-tag ancestry masks, and
// retires or kills tags on branch resolution with registered resolve outputs.
module spectag_manager
  import spectag_manager_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exception,
  input  logic [RENAME_RATE-1:0]     rn_is_branch,
  input  logic                       rn_fire,
  output logic                       rn_tag_stall,
  output spectag_t [RENAME_RATE-1:0] rn_spectag_bus,
  output spectag_t [RENAME_RATE-1:0] rn_killmask_bus,
  input  logic                       br_resolve_valid,
  input  logic                       br_mispredict,
  input  spectag_t                   br_spectag,
  output logic                       Branch_Mispredicted,
  output logic                       Update_KillMask,
  output spectag_t                   Mispredicted_SpecTag,
  output spectag_t                   SpecTag_Valid,
  output tag_cnt_t                   free_tag_cnt
);

  spectag_t                   valid_r, valid_nx, free_vec;
  spectag_t [SPEC_STATES-1:0] brmask_r, brmask_nx;
  spectag_t [RENAME_RATE-1:0] grant;
  tag_cnt_t                   grant_cnt;
  spectag_t                   granted_below, kill_set;
  logic                       res_hit, res_good, res_bad, commit;
  logic                       br_mis_p1, upd_km_p1;
  spectag_t                   res_tag_p1;

  assign free_vec = ~valid_r;

  spectag_alloc_pri u_pri (
    .free_vec  (free_vec),
    .req       (rn_is_branch),
    .grant     (grant),
    .grant_cnt (grant_cnt)
  );

  always_comb begin
    granted_below   = '0;
    rn_killmask_bus = '0;
    for (int i = 0; i < RENAME_RATE; i++) begin
      rn_killmask_bus[i] = valid_r | granted_below;
      granted_below      = granted_below | grant[i];
    end
  end

  assign rn_spectag_bus = grant;
  assign free_tag_cnt   = tag_cnt_t'(SPEC_STATES) - popcount(valid_r);
  // A short grant count means the group does not fit; the whole group stalls.
  assign rn_tag_stall   = (grant_cnt != popcount(spectag_t'(rn_is_branch))) |
                          (br_resolve_valid & br_mispredict);
  assign commit         = rn_fire & ~rn_tag_stall;

  // Resolves of already-killed or malformed tags are dropped.
  assign res_hit  = br_resolve_valid & $onehot(br_spectag) & (|(br_spectag & valid_r));
  assign res_good = res_hit & ~br_mispredict;
  assign res_bad  = res_hit & br_mispredict;

  always_comb begin
    kill_set  = br_spectag;
    valid_nx  = valid_r;
    brmask_nx = brmask_r;
    for (int t = 0; t < SPEC_STATES; t++) begin
      if (|(brmask_r[t] & br_spectag)) kill_set[t] = 1'b1;
    end
    if (commit) begin
      for (int i = 0; i < RENAME_RATE; i++) begin
        if (|grant[i]) begin
          valid_nx = valid_nx | grant[i];
          brmask_nx[onehot_to_idx(grant[i])] = rn_killmask_bus[i];
        end
      end
    end
    // Applied after commit so newly granted masks also drop the retired tag.
    if (res_good) begin
      valid_nx = valid_nx & ~br_spectag;
      for (int t = 0; t < SPEC_STATES; t++) begin
        brmask_nx[t] = brmask_nx[t] & ~br_spectag;
      end
    end
    if (res_bad) valid_nx = valid_nx & ~kill_set;
  end

  // Stage p0 -> p1: state update and registered resolve outputs
  always_ff @(posedge clk) begin
    if (rst | exception) begin
      valid_r    <= '0;
      brmask_r   <= '0;
      br_mis_p1  <= 1'b0;
      upd_km_p1  <= 1'b0;
      res_tag_p1 <= '0;
    end else begin
      valid_r    <= valid_nx;
      brmask_r   <= brmask_nx;
      br_mis_p1  <= res_bad;
      upd_km_p1  <= res_good;
      res_tag_p1 <= res_hit ? br_spectag : '0;
    end
  end

  assign Branch_Mispredicted  = br_mis_p1;
  assign Update_KillMask      = upd_km_p1;
  assign Mispredicted_SpecTag = res_tag_p1;
  assign SpecTag_Valid        = valid_r;

  a_onehot_tag: assert property (@(posedge clk) disable iff (rst)
    br_resolve_valid |-> $onehot(br_spectag));
  a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
    !(Branch_Mispredicted && Update_KillMask));

endmodule

// File: tb/tb_spectag_manager.sv
// Directed and model-checked stimulus for spectag_manager.
module tb_spectag_manager;
  import spectag_manager_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst, exception, rn_fire, rn_tag_stall;
  logic [RENAME_RATE-1:0]     rn_is_branch;
  spectag_t [RENAME_RATE-1:0] rn_spectag_bus, rn_killmask_bus;
  logic                       br_resolve_valid, br_mispredict;
  spectag_t                   br_spectag;
  logic                       Branch_Mispredicted, Update_KillMask;
  spectag_t                   Mispredicted_SpecTag, SpecTag_Valid;
  tag_cnt_t                   free_tag_cnt;

  int n_chk = 0;
  int n_pass = 0;

  spectag_manager dut (
    .clk                  (clk),
    .rst                  (rst),
    .exception            (exception),
    .rn_is_branch         (rn_is_branch),
    .rn_fire              (rn_fire),
    .rn_tag_stall         (rn_tag_stall),
    .rn_spectag_bus       (rn_spectag_bus),
    .rn_killmask_bus      (rn_killmask_bus),
    .br_resolve_valid     (br_resolve_valid),
    .br_mispredict        (br_mispredict),
    .br_spectag           (br_spectag),
    .Branch_Mispredicted  (Branch_Mispredicted),
    .Update_KillMask      (Update_KillMask),
    .Mispredicted_SpecTag (Mispredicted_SpecTag),
    .SpecTag_Valid        (SpecTag_Valid),
    .free_tag_cnt         (free_tag_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic idle();
    exception = 1'b0; rn_is_branch = '0; rn_fire = 1'b0;
    br_resolve_valid = 1'b0; br_mispredict = 1'b0; br_spectag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [1:0] br);
    rn_is_branch = br; rn_fire = 1'b1;
    tick();
    idle();
  endtask

  task automatic resolve(input logic mp, input spectag_t tag);
    br_resolve_valid = 1'b1; br_mispredict = mp; br_spectag = tag;
    tick();
    idle();
  endtask

  task automatic stress(input int ncyc);
    logic [1:0] br;
    logic [3:0] mv, nv, eg0, eg1, km1;
    logic [3:0] mm[4];
    logic [3:0] nm[4];
    int         g0, g1, nfree, nb, ti;
    bit         fire, rv, mp, exc, stl, hit, ebm, euk;
    mv = '0;
    for (int t = 0; t < 4; t++) mm[t] = '0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      br   = 2'($urandom_range(0, 3));
      fire = 1'($urandom_range(0, 1));
      rv   = ($urandom_range(0, 2) != 0);
      mp   = ($urandom_range(0, 2) == 0);
      ti   = int'($urandom_range(0, 3));
      exc  = ($urandom_range(0, 24) == 0);
      g0 = -1; g1 = -1; nfree = 0;
      for (int t = 0; t < 4; t++) begin
        if (!mv[t]) begin
          nfree++;
          if (br[0] && g0 < 0) g0 = t;
          else if (br[1] && g1 < 0) g1 = t;
        end
      end
      eg0 = (g0 >= 0) ? (4'b0001 << g0) : 4'b0000;
      eg1 = (g1 >= 0) ? (4'b0001 << g1) : 4'b0000;
      km1 = mv | eg0;
      nb  = int'(br[0]) + int'(br[1]);
      stl = (nb > nfree) || (rv && mp);
      exception = exc; rn_is_branch = br; rn_fire = fire;
      br_resolve_valid = rv; br_mispredict = mp; br_spectag = 4'b0001 << ti;
      #1;
      chk("rs_stall", rn_tag_stall, stl);
      chk("rs_grant0", rn_spectag_bus[0], eg0);
      chk("rs_grant1", rn_spectag_bus[1], eg1);
      chk("rs_km0", rn_killmask_bus[0], mv);
      chk("rs_km1", rn_killmask_bus[1], km1);
      chk("rs_free", free_tag_cnt, 32'(nfree));
      nv = mv;
      for (int t = 0; t < 4; t++) nm[t] = mm[t];
      hit = rv && mv[ti];
      ebm = 1'b0; euk = 1'b0;
      if (exc) begin
        nv = '0;
        for (int t = 0; t < 4; t++) nm[t] = '0;
      end else begin
        if (fire && !stl) begin
          if (g0 >= 0) begin nv[g0] = 1'b1; nm[g0] = mv; end
          if (g1 >= 0) begin nv[g1] = 1'b1; nm[g1] = km1; end
        end
        if (hit && !mp) begin
          nv[ti] = 1'b0;
          for (int t = 0; t < 4; t++) nm[t][ti] = 1'b0;
        end
        if (hit && mp) begin
          nv[ti] = 1'b0;
          for (int t = 0; t < 4; t++) if (mm[t][ti]) nv[t] = 1'b0;
        end
        ebm = hit && mp;
        euk = hit && !mp;
      end
      tick();
      idle();
      mv = nv;
      for (int t = 0; t < 4; t++) mm[t] = nm[t];
      chk("rs_valid", SpecTag_Valid, mv);
      chk("rs_bm", Branch_Mispredicted, ebm);
      chk("rs_uk", Update_KillMask, euk);
      if (ebm || euk) chk("rs_tag", Mispredicted_SpecTag, 4'b0001 << ti);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", SpecTag_Valid, 4'b0000);
    chk("rst_free", free_tag_cnt, 4);
    chk("rst_bm", Branch_Mispredicted, 0);
    chk("rst_uk", Update_KillMask, 0);
    chk("rst_tag", Mispredicted_SpecTag, 0);

    // Two-branch group from empty
    rn_is_branch = 2'b11; rn_fire = 1'b1;
    #1;
    chk("t1_g0", rn_spectag_bus[0], 4'b0001);
    chk("t1_g1", rn_spectag_bus[1], 4'b0010);
    chk("t1_km0", rn_killmask_bus[0], 4'b0000);
    chk("t1_km1", rn_killmask_bus[1], 4'b0001);
    chk("t1_stall", rn_tag_stall, 0);
    tick(); idle();
    chk("t1_valid", SpecTag_Valid, 4'b0011);
    chk("t1_free", free_tag_cnt, 2);

    // Shortage stalls the whole group; a single branch still fits
    alloc(2'b01);
    chk("t2_valid0", SpecTag_Valid, 4'b0111);
    rn_is_branch = 2'b11; rn_fire = 1'b1;
    #1;
    chk("t2_stall", rn_tag_stall, 1);
    tick(); idle();
    chk("t2_valid1", SpecTag_Valid, 4'b0111);
    rn_is_branch = 2'b01; rn_fire = 1'b1;
    #1;
    chk("t2_g0", rn_spectag_bus[0], 4'b1000);
    chk("t2_g1", rn_spectag_bus[1], 4'b0000);
    chk("t2_km0", rn_killmask_bus[0], 4'b0111);
    chk("t2_nostall", rn_tag_stall, 0);
    tick(); idle();
    chk("t2_valid2", SpecTag_Valid, 4'b1111);
    chk("t2_free", free_tag_cnt, 0);

    // Mispredict of tag 1 kills tags 1..3
    br_resolve_valid = 1'b1; br_mispredict = 1'b1; br_spectag = 4'b0010;
    #1;
    chk("t3_stall", rn_tag_stall, 1);
    tick(); idle();
    chk("t3_bm", Branch_Mispredicted, 1);
    chk("t3_uk", Update_KillMask, 0);
    chk("t3_tag", Mispredicted_SpecTag, 4'b0010);
    chk("t3_valid", SpecTag_Valid, 4'b0001);
    tick();
    chk("t3_bm_off", Branch_Mispredicted, 0);

    // Correct resolve of tag 0 concurrent with a grant of tag 2
    alloc(2'b01);
    chk("t4_valid0", SpecTag_Valid, 4'b0011);
    rn_is_branch = 2'b01; rn_fire = 1'b1;
    br_resolve_valid = 1'b1; br_mispredict = 1'b0; br_spectag = 4'b0001;
    #1;
    chk("t4_g0", rn_spectag_bus[0], 4'b0100);
    chk("t4_km0", rn_killmask_bus[0], 4'b0011);
    chk("t4_stall", rn_tag_stall, 0);
    tick(); idle();
    chk("t4_uk", Update_KillMask, 1);
    chk("t4_bm", Branch_Mispredicted, 0);
    chk("t4_tag", Mispredicted_SpecTag, 4'b0001);
    chk("t4_valid", SpecTag_Valid, 4'b0110);
    chk("t4_mask2", dut.brmask_r[2], 4'b0010);
    chk("t4_mask1", dut.brmask_r[1], 4'b0000);

    // Exception beats a concurrent mispredict and fire
    exception = 1'b1; rn_is_branch = 2'b01; rn_fire = 1'b1;
    br_resolve_valid = 1'b1; br_mispredict = 1'b1; br_spectag = 4'b0010;
    tick(); idle();
    chk("t5_valid", SpecTag_Valid, 4'b0000);
    chk("t5_bm", Branch_Mispredicted, 0);
    chk("t5_uk", Update_KillMask, 0);
    chk("t5_free", free_tag_cnt, 4);
    chk("t5_masks", 32'(dut.brmask_r), 0);

    // Exact fit without fire, then resolves of killed tags
    alloc(2'b11);
    rn_is_branch = 2'b11;
    #1;
    chk("t6_fit_stall", rn_tag_stall, 0);
    chk("t6_fit_g0", rn_spectag_bus[0], 4'b0100);
    chk("t6_fit_g1", rn_spectag_bus[1], 4'b1000);
    chk("t6_fit_km1", rn_killmask_bus[1], 4'b0111);
    tick(); idle();
    chk("t6_nofire", SpecTag_Valid, 4'b0011);
    resolve(1'b1, 4'b0001);
    chk("t6_bm", Branch_Mispredicted, 1);
    chk("t6_valid0", SpecTag_Valid, 4'b0000);
    resolve(1'b0, 4'b0010);
    chk("t6_dead_uk", Update_KillMask, 0);
    chk("t6_dead_bm0", Branch_Mispredicted, 0);
    resolve(1'b1, 4'b0001);
    chk("t6_dead_bm1", Branch_Mispredicted, 0);
    chk("t6_valid1", SpecTag_Valid, 4'b0000);
    chk("t6_free", free_tag_cnt, 4);

    stress(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
